// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider reload controller.
package div_ctrl_pkg;

    typedef logic [1:0] state_t;
    typedef logic [7:0] ratio_t;

    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_LOAD   = 2'd1;
    localparam state_t S_SETTLE = 2'd2;
    localparam state_t S_RUN    = 2'd3;

    localparam ratio_t MIN_RATIO = 8'd2;

    // The counters reload with N-1 so that a full period spans N clocks.
    function automatic ratio_t load_value(input ratio_t r);
        return r - 8'd1;
    endfunction

endpackage

// File: rtl/div_ctrl_timer.sv
// Loadable saturating down-counter; tc flags terminal count (zero).
module div_ctrl_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         tc
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/div_reload_ctrl.sv
// Load/settle/run sequencer for a cascaded two-nibble divider with auto-reload.
// Optional watchdog on missing borrows: define DIV_WATCHDOG_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_IDLE   | divider halted, waiting for a valid request
// S_LOAD   | load_n low for one cycle, counters take ld_hi/ld_lo
// S_SETTLE | counters loaded, cnt_en held low for SETTLE_CYC cycles
// S_RUN    | counting; each borrow triggers reload and a tick
module div_reload_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned WDT_CYC    = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  ratio_t     ratio,
    input  logic       stop,
    input  logic       co_n,
    output logic       ack,
    output logic       err,
    output logic [3:0] ld_lo,
    output logic [3:0] ld_hi,
    output logic       load_n,
    output logic       cnt_en,
    output logic       tick,
    output logic       busy,
    output logic       stall
);

`ifdef DIV_WATCHDOG_EN
    localparam int unsigned TW = 16;
    localparam logic [TW-1:0] WDT_LD = TW'(WDT_CYC - 1);
`else
    localparam int unsigned TW = 8;
`endif
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);

    if (SETTLE_CYC < 1 || SETTLE_CYC > 255 || WDT_CYC < 16 || WDT_CYC > 65535) begin : g_bad_param
        $error("div_reload_ctrl: SETTLE_CYC or WDT_CYC out of range");
    end

    state_t  state_q, state_d;
    ratio_t  act_q, pend_q, ld_q;
    logic    pend_vld_q;
    logic    ack_q, err_q, tick_q, reload_q;
    logic    tmr_load, tmr_dec, tmr_tc;
    logic [TW-1:0] tmr_val;
    logic    borrow, wdt_trip, halt, req_ok, ratio_ok;

    assign borrow   = (state_q == S_RUN) && !co_n;
    assign halt     = stop || wdt_trip;
    // A request arriving while ack is still high is the same request held over.
    assign req_ok   = req && !halt && !ack_q;
    assign ratio_ok = (ratio >= MIN_RATIO);

`ifdef DIV_WATCHDOG_EN
    logic stall_q;

    assign wdt_trip = (state_q == S_RUN) && co_n && tmr_tc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= wdt_trip && !stop;
        end
    end

    assign stall = stall_q;
`else
    assign wdt_trip = 1'b0;
    assign stall    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        if (halt) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_ok && ratio_ok) begin
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    state_d  = S_SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                end
                S_SETTLE: begin
                    if (tmr_tc) begin
                        state_d = S_RUN;
`ifdef DIV_WATCHDOG_EN
                        tmr_load = 1'b1;
                        tmr_val  = WDT_LD;
`endif
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                S_RUN: begin
`ifdef DIV_WATCHDOG_EN
                    if (borrow) begin
                        tmr_load = 1'b1;
                        tmr_val  = WDT_LD;
                    end else begin
                        tmr_dec = 1'b1;
                    end
`endif
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    div_ctrl_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            act_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            ld_q       <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            tick_q     <= 1'b0;
            reload_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            tick_q   <= 1'b0;
            reload_q <= 1'b0;
            if (halt) begin
                pend_vld_q <= 1'b0;
            end else begin
                if (borrow) begin
                    reload_q <= 1'b1;
                    tick_q   <= 1'b1;
                    if (pend_vld_q) begin
                        ld_q       <= load_value(pend_q);
                        act_q      <= pend_q;
                        pend_vld_q <= 1'b0;
                    end else begin
                        ld_q <= load_value(act_q);
                    end
                end
                // Placed after the reload so a same-cycle request lands in pending.
                if (req_ok) begin
                    if (!ratio_ok) begin
                        err_q <= 1'b1;
                    end else begin
                        ack_q <= 1'b1;
                        if (state_q == S_IDLE) begin
                            act_q <= ratio;
                            ld_q  <= load_value(ratio);
                        end else begin
                            pend_q     <= ratio;
                            pend_vld_q <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign ack    = ack_q;
    assign err    = err_q;
    assign tick   = tick_q;
    assign ld_hi  = ld_q[7:4];
    assign ld_lo  = ld_q[3:0];
    assign load_n = !((state_q == S_LOAD) || reload_q);
    assign cnt_en = (state_q == S_RUN);
    assign busy   = (state_q != S_IDLE);

endmodule

// File: doc/div_reload_ctrl.md
DIV_RELOAD_CTRL -- requirements
Module: div_reload_ctrl

Interface
REQ-001 SETTLE_CYC, default 4, number of idle cycles between the initial load and count enable (range 1..255).
REQ-002 WDT_CYC, default 1024, number of RUN cycles without a borrow before a stall is flagged (range 16..65535).
REQ-003 CLK  in  1  single system clock, rising-edge.
REQ-004 RST_N  in  1  asynchronous active-low reset.
REQ-005 req  in  1  host request: apply divide ratio.
REQ-006 ratio  in  8  requested divide ratio, valid with req.
REQ-007 stop  in  1  host stop: halt the divider.
REQ-008 co_n  in  1  active-low borrow from the cascaded high counter, synchronous to CLK.
REQ-009 ack  out  1  one-cycle pulse: request accepted.
REQ-010 err  out  1  one-cycle pulse: request rejected.
REQ-011 ld_lo  out  4  low-counter load nibble (D..A).
REQ-012 ld_hi  out  4  high-counter load nibble (D..A).
REQ-013 load_n  out  1  active-low parallel-load strobe, shared by both counters.
REQ-014 cnt_en  out  1  count enable to the divider.
REQ-015 tick  out  1  one-cycle pulse per completed divide period.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 stall  out  1  one-cycle watchdog pulse.

Function
REQ-018 States: IDLE, LOAD, SETTLE, RUN, encoded in 2 bits.
REQ-019 A request with ratio < 2 shall be rejected: err=1 for one cycle, ack=0, state and outputs unchanged.
REQ-020 IDLE: a valid req shall latch ratio into the active register, pulse ack the next cycle and enter LOAD.
REQ-021 Load value = ratio-1; ld_hi = bits[7:4], ld_lo = bits[3:0]; ld_* outputs remain stable outside load cycles.
REQ-022 LOAD: load_n=0 for exactly one cycle with cnt_en=0, then SETTLE.
REQ-023 SETTLE: cnt_en=0 for SETTLE_CYC cycles, then RUN.
REQ-024 RUN: cnt_en=1; a cycle with co_n=0 shall cause load_n=0 in the next cycle (auto-reload) and a tick pulse in that same cycle.
REQ-025 A valid req in RUN shall be acked and held in a one-deep pending register; at the next borrow the reload uses the pending value, which then becomes active; a newer req overwrites the pending value (last wins).
REQ-026 Simultaneous co_n=0 and req: the reload uses the old active value and the request becomes pending.
REQ-027 A valid req in LOAD or SETTLE shall be acked and held pending; it is applied at the first borrow in RUN.
REQ-028 stop has priority over req and co_n in every state: next cycle IDLE, cnt_en=0, load_n=1, pending cleared; a req in the same cycle is ignored (no ack, no err).
REQ-029 A req in the same cycle as stop, or presented while ack is high, shall not be double-acked.

Reset
REQ-030 RST_N low shall asynchronously force IDLE, ack=err=tick=stall=0, load_n=1, cnt_en=0, ld_lo=ld_hi=0, active and pending registers cleared, and all counters zeroed.
REQ-031 Reset asserted mid-LOAD shall release load_n immediately, without waiting for a clock edge.

Configuration
REQ-032 DIV_WATCHDOG_EN defined: RUN counts cycles since the last borrow; reaching WDT_CYC shall pulse stall and enter IDLE with stop semantics.
REQ-033 DIV_WATCHDOG_EN undefined: no watchdog counter shall exist, and stall shall be tied to 0.

Structure
REQ-034 A shared package div_ctrl_pkg shall hold the state enumeration, the 8-bit ratio type and the minimum-ratio constant (2).
REQ-035 One sub-module, div_ctrl_timer: loadable down-counter serving both the SETTLE and watchdog countdowns.

Verification
REQ-036 Reset, then req with ratio=0x0F: ack at +1, load_n low one cycle with ld_hi=0x0, ld_lo=0xE; cnt_en rises after 4 SETTLE cycles.
REQ-037 ratio=1, then ratio=0: err pulses each time, no ack, busy stays 0.
REQ-038 In RUN at ratio=0x0F, req ratio=0x80: reload at the next borrow uses ld_hi=0x7, ld_lo=0xF, and tick continues without a gap.
REQ-039 co_n=0 and req ratio=0x20 in the same cycle: reload uses the old value, and the following reload uses 0x1F.
REQ-040 stop asserted during SETTLE: IDLE at +1, cnt_en never rises, pending request discarded.
REQ-041 With DIV_WATCHDOG_EN defined and co_n held high in RUN: stall pulses after exactly 1024 cycles and busy drops; RST_N pulsed mid-LOAD returns load_n=1 asynchronously.
